// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t            : control FSM states (IDLE, SHIFT, DONE)
//   SUB_WIDTH_DEFAULT  : default operand width in bits
//   cnt_w()            : width of the bit counter for a given operand width
package serial_subtractor_8bit_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Request/result bundle of the bit-serial subtractor.
//   start, A, B, C          : request (start pulse, minuend, subtrahend, borrow-in)
//   diff, borrow, busy, done: result and status
//   ovf                     : signed overflow, only with SUB_OVERFLOW_EN defined
// master drives the request, slave (the subtractor) drives the result.
interface serial_subtractor_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, A, B, C, input diff, borrow, busy, done, ovf);
  modport slave  (input start, A, B, C, output diff, borrow, busy, done, ovf);
`else
  modport master (output start, A, B, C, input diff, borrow, busy, done);
  modport slave  (input start, A, B, C, output diff, borrow, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = A - B - C mod 2^WIDTH, one bit per clock,
// LSB first, through a single full_subtractor.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_subtractor_8bit_if
//                (start/A/B/C in, diff/borrow/busy/done[/ovf] out)
// Optional feature: define SUB_OVERFLOW_EN to add the signed overflow flag ovf.
// WIDTH must be at least 2.
//
// Timing, start accepted at edge 0: edges 1..WIDTH run the bit steps,
// edge WIDTH+1 (in DONE) loads diff/borrow and raises done for one cycle.
// All outputs are registered, so busy/done lag the state register by one
// edge decision, and DONE itself accepts a new start (back-to-back).
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_subtractor_8bit_if.slave bus
);

  localparam int              CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;     // remaining minuend bits, current bit at [0]
  logic [WIDTH-1:0] b_sr;     // remaining subtrahend bits, current bit at [0]
  logic [WIDTH-1:0] res_sr;   // difference bits enter at the MSB
  logic             bin_r;    // borrow chained between bit steps
  logic [CW-1:0]    cnt;
  logic             fs_d;
  logic             fs_bout;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_pend; // borrow-in differs from borrow-out at the MSB step
`endif

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_r),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      bin_r      <= 1'b0;
      cnt        <= '0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_pend   <= 1'b0;
      bus.ovf    <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.A;
            b_sr     <= bus.B;
            bin_r    <= bus.C;
            res_sr   <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end

        // start is not looked at here: a request while busy is dropped.
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          bin_r  <= fs_bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.busy <= 1'b0;
            state    <= DONE;
`ifdef SUB_OVERFLOW_EN
            ovf_pend <= bin_r ^ fs_bout;
`endif
          end
        end

        DONE: begin
          bus.diff   <= res_sr;
          bus.borrow <= bin_r;   // final borrow-out of the MSB step
          bus.done   <= 1'b1;
`ifdef SUB_OVERFLOW_EN
          bus.ovf    <= ovf_pend;
`endif
          if (bus.start) begin
            a_sr     <= bus.A;
            b_sr     <= bus.B;
            bin_r    <= bus.C;
            res_sr   <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed vectors with
// literal expectations plus a cycle-level reference model (arithmetic result
// and fixed latency) compared against the DUT on every falling edge.
// Define SUB_OVERFLOW_EN to also cover the ovf output.
module tb_serial_subtractor_8bit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  serial_subtractor_8bit_if #(.WIDTH(W)) sif ();

  serial_subtractor_8bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is taken when nothing is in flight or on the
  // cycle the previous result is delivered; the result appears WIDTH+1 edges
  // after acceptance.
  int             left;
  logic [W-1:0]   m_diff, p_diff;
  logic           m_borrow, p_borrow, m_ovf, p_ovf, m_done, m_busy;

  always @(posedge clk or negedge rst_n) begin
    int old, full, sres;
    if (!rst_n) begin
      left = 0; m_done = 0; m_busy = 0;
      m_diff = '0; m_borrow = 0; m_ovf = 0;
    end else begin
      old = left;
      m_done = 0;
      if (left > 0) left--;
      if (old == 1) begin
        m_done = 1; m_diff = p_diff; m_borrow = p_borrow; m_ovf = p_ovf;
      end
      if ((old == 0 || old == 1) && sif.start) begin
        full     = int'(sif.A) - int'(sif.B) - int'(sif.C);
        p_diff   = full[W-1:0];
        p_borrow = (full < 0);
        sres     = int'($signed(sif.A)) - int'($signed(sif.B)) - int'(sif.C);
        p_ovf    = (sres < -(2 ** (W - 1))) || (sres > (2 ** (W - 1)) - 1);
        left     = W + 1;
      end
      m_busy = (left >= 2);
    end
  end

  always @(negedge clk) begin
    if (sif.done) done_cnt++;
    if (rst_n) begin
      chk("model_done",   32'(sif.done),   32'(m_done));
      chk("model_busy",   32'(sif.busy),   32'(m_busy));
      chk("model_diff",   32'(sif.diff),   32'(m_diff));
      chk("model_borrow", 32'(sif.borrow), 32'(m_borrow));
`ifdef SUB_OVERFLOW_EN
      chk("model_ovf",    32'(sif.ovf),    32'(m_ovf));
`endif
    end
  end

  // Waits on falling edges for done; lat counts edges seen, busy_n the busy ones.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!sif.done && lat < 40) begin
      if (sif.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!sif.done) chk("timeout_done", 32'd0, 32'd1);
  endtask

  // One start pulse; inputs are scrambled after acceptance.
  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input logic [W-1:0] ed, input logic eb);
    int lat, bn;
    @(negedge clk);
    sif.start = 1; sif.A = a; sif.B = b; sif.C = c;
    @(negedge clk);
    sif.start = 0; sif.A = ~a; sif.B = ~b; sif.C = ~c;
    wait_done(lat, bn);
    chk({name, "_diff"},   32'(sif.diff),   32'(ed));
    chk({name, "_borrow"}, 32'(sif.borrow), 32'(eb));
  endtask

  initial begin
    int lat, bn, d0;
    sif.start = 0; sif.A = '0; sif.B = '0; sif.C = 0;
    repeat (3) @(negedge clk);
    chk("rst_diff",   32'(sif.diff),   32'd0);
    chk("rst_borrow", 32'(sif.borrow), 32'd0);
    chk("rst_busy",   32'(sif.busy),   32'd0);
    chk("rst_done",   32'(sif.done),   32'd0);
    rst_n = 1;

    // Basic op with latency and busy length
    @(negedge clk);
    sif.start = 1; sif.A = 8'h10; sif.B = 8'h01; sif.C = 0;
    @(negedge clk);
    sif.start = 0;
    wait_done(lat, bn);
    chk("lat_edges",  32'(lat - 1), 32'(W + 1));
    chk("busy_cycles", 32'(bn),     32'(W));
    chk("basic_diff",   32'(sif.diff),   32'h0F);
    chk("basic_borrow", 32'(sif.borrow), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(sif.done), 32'd0);

    op("v1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op("v2", 8'hAA, 8'hAA, 1'b1, 8'hFF, 1'b1);
    op("v3", 8'h64, 8'h24, 1'b1, 8'h3F, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    d0 = done_cnt;
    sif.start = 1; sif.A = 8'h3C; sif.B = 8'h12; sif.C = 0;
    @(negedge clk); sif.start = 0;
    repeat (2) @(negedge clk);
    sif.start = 1; sif.A = 8'hFF; sif.B = 8'h00;
    @(negedge clk); sif.start = 0;
    wait_done(lat, bn);
    chk("ign_diff",   32'(sif.diff),   32'h2A);
    chk("ign_borrow", 32'(sif.borrow), 32'd0);
    repeat (12) @(negedge clk);
    chk("ign_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Back-to-back with start held high
    sif.start = 1; sif.A = 8'h10; sif.B = 8'h01; sif.C = 0;
    @(negedge clk);
    sif.A = 8'hBF; sif.B = 8'hAD;
    wait_done(lat, bn);
    chk("b2b_first_diff", 32'(sif.diff), 32'h0F);
    chk("b2b_no_idle",    32'(sif.busy), 32'd1);
    sif.start = 0;
    @(negedge clk);
    wait_done(lat, bn);
    chk("b2b_second_diff",   32'(sif.diff),   32'h12);
    chk("b2b_second_borrow", 32'(sif.borrow), 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    sif.start = 1; sif.A = 8'h20; sif.B = 8'h10; sif.C = 0;
    @(negedge clk); sif.start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_diff", 32'(sif.diff), 32'd0);
    chk("abort_busy", 32'(sif.busy), 32'd0);
    chk("abort_done", 32'(sif.done), 32'd0);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    op("after_rst", 8'h20, 8'h10, 1'b0, 8'h10, 1'b0);

`ifdef SUB_OVERFLOW_EN
    op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    chk("ovf1_ovf", 32'(sif.ovf), 32'd1);
    op("ovf0", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
    chk("ovf0_ovf", 32'(sif.ovf), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
